// File: rtl/sd_block_responder.sv
// SD sector responder: moves 512-byte sectors between the SD buffer and a byte memory; SD_RESP_WRITE_EN adds writes.
// Latency: 1 accept cycle, then (mem_ready wait + 2) cycles per byte, then 1 DONE cycle.
// Backpressure: mem_rd/mem_wr are held until mem_ready; out-of-range bytes skip memory entirely.
module sd_block_responder (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_din,
  input  logic [31:0] img_size,
  input  logic        img_mounted,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_WAIT, WR_REQ, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [22:0] lba_q;
  logic [9:0]  cnt;
  logic [7:0]  rdata_q;
  logic        in_range;
  logic        last_byte;
  logic        unused_lba_hi;

  // Only 23 sector bits fit a 32-bit byte address; the rest are dropped.
  assign unused_lba_hi = ^sd_lba[31:23];

  assign mem_addr     = {lba_q, 9'b0} + {22'b0, cnt};
  assign in_range     = img_mounted && (mem_addr < img_size);
  assign last_byte    = (cnt == 10'd511);
  assign sd_ack       = (state != IDLE) && (state != DONE);
  assign sd_buff_wr   = (state == RD_PUT);
  assign sd_buff_dout = rdata_q;
  assign mem_rd       = (state == RD_REQ) && in_range;

`ifdef SD_RESP_WRITE_EN
  logic       wait_q;
  logic [7:0] wdata_q;

  assign sd_buff_addr = cnt[8:0];
  assign mem_wr       = (state == WR_REQ) && in_range;
  assign mem_wdata    = wdata_q;

  // The buffer returns data two cycles after the address; wait_q marks the second wait cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_q  <= 1'b0;
      wdata_q <= 8'h00;
    end else if (state == WR_ADDR) begin
      wait_q <= 1'b0;
    end else if (state == WR_WAIT) begin
      wait_q <= 1'b1;
      if (wait_q) wdata_q <= sd_buff_din;
    end
  end
`else
  logic unused_din;

  // Writes are only acknowledged: the buffer is never addressed and memory never written.
  assign unused_din   = ^sd_buff_din;
  assign sd_buff_addr = (state == WR_ADDR) ? 9'd0 : cnt[8:0];
  assign mem_wr       = 1'b0;
  assign mem_wdata    = 8'h00;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sd_rd)      state_nxt = RD_REQ;
        else if (sd_wr) state_nxt = WR_ADDR;
      end
      RD_REQ:  if (!in_range || mem_ready) state_nxt = RD_PUT;
      RD_PUT:  state_nxt = last_byte ? DONE : RD_REQ;
`ifdef SD_RESP_WRITE_EN
      WR_ADDR: state_nxt = WR_WAIT;
      WR_WAIT: if (wait_q) state_nxt = WR_REQ;
      WR_REQ:  if (!in_range || mem_ready) state_nxt = last_byte ? DONE : WR_ADDR;
`else
      WR_ADDR: if (cnt == 10'd512) state_nxt = DONE;
`endif
      DONE:    if (!sd_rd && !sd_wr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lba_q   <= 23'd0;
      cnt     <= 10'd0;
      rdata_q <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (sd_rd || sd_wr) begin
            lba_q <= sd_lba[22:0];
            cnt   <= 10'd0;
          end
        end
        RD_REQ: begin
          if (!in_range)      rdata_q <= 8'h00;
          else if (mem_ready) rdata_q <= mem_rdata;
        end
        RD_PUT: cnt <= cnt + 10'd1;
`ifdef SD_RESP_WRITE_EN
        WR_REQ: if (!in_range || mem_ready) cnt <= cnt + 10'd1;
`else
        WR_ADDR: if (cnt != 10'd512) cnt <= cnt + 10'd1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// Directed bench for sd_block_responder: table of whole-sector transfers plus reset and request-overlap sequences.
module tb_sd_block_responder;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] sd_lba = 32'd0;
  logic        sd_rd = 1'b0;
  logic        sd_wr = 1'b0;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din = 8'h00;
  logic [31:0] img_size = 32'd0;
  logic        img_mounted = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_ready = 1'b0;

  always #5 CLK = ~CLK;

  sd_block_responder dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .img_size(img_size), .img_mounted(img_mounted),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  // Scenario descriptors, written only by the main sequence.
  logic [31:0] cur_base = 32'd0;
  logic [31:0] cur_size = 32'd0;
  logic        cur_mounted = 1'b0;
  int          cur_delay = 0;
  int          strobe_base = 0;
  int          wr_base = 0;

  // Monitor counters, written only by the negedge monitor.
  int strobe_cnt = 0, rd_txn = 0, wr_txn = 0, ack_cyc = 0;
  int data_err = 0, addr_err = 0, wcnt = 0;
  logic       mem_rd_d = 1'b0;
  logic [7:0] bd1 = 8'h00;

  int checks = 0;
  int failures = 0;

  function automatic logic [7:0] exp_byte(input int idx);
    logic [31:0] a;
    a = cur_base + 32'(idx);
    return (cur_mounted && a < cur_size) ? a[7:0] : 8'h00;
  endfunction

  // Memory responder (byte n holds n[7:0]), buffer model (byte a holds ~a) and transfer monitor.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      mem_ready = 1'b0;
      wcnt      = 0;
      mem_rd_d  = 1'b0;
    end else begin
      if (sd_ack) ack_cyc++;
      if (sd_buff_wr) begin
        if (sd_buff_addr != 9'(strobe_cnt - strobe_base) ||
            sd_buff_dout != exp_byte(strobe_cnt - strobe_base)) data_err++;
        strobe_cnt++;
      end
      if (mem_rd && mem_wr) addr_err++;
      if (mem_rd && mem_addr != cur_base + 32'(strobe_cnt - strobe_base)) addr_err++;
      if (mem_wr && (mem_addr != cur_base + 32'(wr_txn - wr_base) ||
                     mem_wdata != ~mem_addr[7:0])) data_err++;
      if (mem_rd && !mem_rd_d) rd_txn++;
      mem_rd_d = mem_rd;
      if (mem_ready) begin
        mem_ready = 1'b0;
        wcnt      = 0;
      end else if (mem_rd || mem_wr) begin
        if (wcnt >= cur_delay) begin
          mem_ready = 1'b1;
          mem_rdata = mem_addr[7:0];
          if (mem_wr) wr_txn++;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
      sd_buff_din = bd1;
      bd1         = ~sd_buff_addr[7:0];
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic setup(input logic [31:0] lba, input logic [31:0] size, input bit mounted, input int delay);
    strobe_base = strobe_cnt;
    wr_base     = wr_txn;
    cur_base    = {lba[22:0], 9'b0};
    cur_size    = size;
    cur_mounted = mounted;
    cur_delay   = delay;
    img_size    = size;
    img_mounted = mounted;
    sd_lba      = lba;
  endtask

  task automatic run_xfer(input bit rd, input bit wr, input logic [31:0] lba, input logic [31:0] size,
                          input bit mounted, input int delay, input bit chg, input int hold,
                          output int o_strobes, output int o_rd, output int o_wr, output int o_ack,
                          output int o_derr, output int o_aerr, output bit o_timeout);
    int s0, r0, w0, a0, d0, e0, g;
    step();
    s0 = strobe_cnt; r0 = rd_txn; w0 = wr_txn; a0 = ack_cyc; d0 = data_err; e0 = addr_err;
    setup(lba, size, mounted, delay);
    sd_rd = rd;
    sd_wr = wr;
    o_timeout = 1'b0;
    g = 0;
    while (!sd_ack && g < 10) begin step(); g++; end
    if (g >= 10) o_timeout = 1'b1;
    if (chg) sd_lba = lba ^ 32'h0000_0005;
    g = 0;
    while (sd_ack && g < 20000) begin step(); g++; end
    if (g >= 20000) o_timeout = 1'b1;
    repeat (hold) step();
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    repeat (3) step();
    o_strobes = strobe_cnt - s0;
    o_rd      = rd_txn - r0;
    o_wr      = wr_txn - w0;
    o_ack     = ack_cyc - a0;
    o_derr    = data_err - d0;
    o_aerr    = addr_err - e0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] lba;
    logic [31:0] size;
    bit          mounted;
    int          delay;
    bit          chg;
    int          hold;
    int          e_strobes;
    int          e_rd;
    int          e_wr;
    int          e_ack;
  } vec_t;

  vec_t vt[9];

  initial begin
    int n_s, n_r, n_w, n_a, n_d, n_e, guard;
    bit to;

    vt[0] = '{1'b1, 1'b0, 32'd1,          32'd1024,     1'b1, 3, 1'b0, 0, 512, 512, 0, 2560};
    vt[1] = '{1'b1, 1'b0, 32'd1,          32'd512,      1'b1, 3, 1'b0, 0, 512, 0,   0, 1024};
    vt[2] = '{1'b1, 1'b0, 32'd1,          32'd768,      1'b1, 1, 1'b1, 0, 512, 256, 0, 1280};
    vt[3] = '{1'b1, 1'b0, 32'd0,          32'd1024,     1'b0, 0, 1'b0, 0, 512, 0,   0, 1024};
    vt[4] = '{1'b1, 1'b0, 32'h0080_0001,  32'd1024,     1'b1, 0, 1'b0, 0, 512, 512, 0, 1024};
`ifdef SD_RESP_WRITE_EN
    vt[5] = '{1'b0, 1'b1, 32'd0,          32'd1024,     1'b1, 2, 1'b0, 0, 0,   0, 512, 3072};
    vt[6] = '{1'b0, 1'b1, 32'd0,          32'd0,        1'b1, 0, 1'b0, 0, 0,   0, 0,   2048};
`else
    vt[5] = '{1'b0, 1'b1, 32'd0,          32'd1024,     1'b1, 2, 1'b0, 0, 0,   0, 0,   513};
    vt[6] = '{1'b0, 1'b1, 32'd0,          32'd0,        1'b1, 0, 1'b0, 0, 0,   0, 0,   513};
`endif
    vt[7] = '{1'b1, 1'b0, 32'd2,          32'hFFFF_FFFF, 1'b1, 0, 1'b0, 0, 512, 512, 0, 1024};
    vt[8] = '{1'b1, 1'b1, 32'd1,          32'd1024,     1'b1, 0, 1'b0, 6, 512, 512, 0, 1024};

    repeat (3) step();
    chk("reset_outputs", {sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_rd, mem_wr, mem_addr, mem_wdata}, 64'd0);
    RESET_N = 1'b1;
    repeat (2) step();
    chk("idle_outputs", {sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_rd, mem_wr, mem_addr, mem_wdata}, 64'd0);

    for (int i = 0; i < 9; i++) begin
      run_xfer(vt[i].rd, vt[i].wr, vt[i].lba, vt[i].size, vt[i].mounted, vt[i].delay,
               vt[i].chg, vt[i].hold, n_s, n_r, n_w, n_a, n_d, n_e, to);
      chk($sformatf("v%0d_timeout", i), 64'(to), 64'd0);
      chk($sformatf("v%0d_strobes", i), 64'(n_s), 64'(vt[i].e_strobes));
      chk($sformatf("v%0d_mem_rd", i), 64'(n_r), 64'(vt[i].e_rd));
      chk($sformatf("v%0d_mem_wr", i), 64'(n_w), 64'(vt[i].e_wr));
      chk($sformatf("v%0d_ack_cycles", i), 64'(n_a), 64'(vt[i].e_ack));
      chk($sformatf("v%0d_data_errs", i), 64'(n_d), 64'd0);
      chk($sformatf("v%0d_addr_errs", i), 64'(n_e), 64'd0);
    end

    // Reset in the middle of a read, right after the 200th byte was delivered.
    step();
    setup(32'd1, 32'd1024, 1'b1, 1);
    sd_rd = 1'b1;
    guard = 0;
    while ((strobe_cnt - strobe_base) < 200 && guard < 5000) begin step(); guard++; end
    chk("rst_reach_byte200", 64'(guard < 5000), 64'd1);
    chk("rst_pre_addr_nonzero", 64'(mem_addr != 32'd0), 64'd1);
    RESET_N = 1'b0;
    #1;
    chk("rst_mid_outputs", {sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_rd, mem_wr, mem_addr, mem_wdata}, 64'd0);
    sd_rd = 1'b0;
    repeat (2) step();
    RESET_N = 1'b1;
    step();
    chk("rst_release_idle", {sd_ack, sd_buff_wr, sd_buff_addr, sd_buff_dout, mem_rd, mem_wr, mem_addr, mem_wdata}, 64'd0);
    run_xfer(1'b1, 1'b0, 32'd1, 32'd1024, 1'b1, 0, 1'b0, 0, n_s, n_r, n_w, n_a, n_d, n_e, to);
    chk("rst_restart_timeout", 64'(to), 64'd0);
    chk("rst_restart_strobes", 64'(n_s), 64'd512);
    chk("rst_restart_mem_rd", 64'(n_r), 64'd512);
    chk("rst_restart_data_errs", 64'(n_d), 64'd0);
    chk("rst_restart_addr_errs", 64'(n_e), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
